uart_bus_sched: RTL and testbench

UART_BUS_SCHED -- requirements
Module: uart_bus_sched

---
 rtl/uart_bus_sched.sv | 152 +++++++++++++++
 tb/tb_uart_bus_sched.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_sched.sv
// Arbitrates two TX requesters onto a UART register port while polling LSR and draining RX bytes.
// Optional sticky line-error capture is enabled by defining UART_BUS_SCHED_ERR_EN.
module uart_bus_sched #(
  parameter logic [15:0] DIVISOR = 16'd15,
  parameter logic [7:0]  LCR_VAL = 8'h03,
  parameter logic [7:0]  FCR_VAL = 8'h07
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       init_done,
  output logic [2:0] err_flags,
  input  logic       err_clr,
  output logic       i_tx_en,
  output logic [2:0] waddr,
  output logic [7:0] wdata,
  output logic       i_rx_en,
  output logic [2:0] raddr,
  input  logic [7:0] rdata
);

  typedef enum logic [2:0] {
    INIT, POLL_ISSUE, POLL_WAIT, POLL_SAMPLE,
    RX_ISSUE, RX_WAIT, RX_SAMPLE, TX_WRITE
  } state_t;

  state_t     state;
  logic [2:0] init_idx;
  logic [2:0] init_addr;
  logic [7:0] init_data;
  logic       grant;
  logic       last_grant;

  // DLAB is raised first so the divisor bytes land in DLL/DLM, then dropped
  always_comb begin
    init_addr = 3'd0;
    init_data = 8'h00;
    case (init_idx)
      3'd0: begin init_addr = 3'd3; init_data = 8'h80 | LCR_VAL; end
      3'd1: begin init_addr = 3'd0; init_data = DIVISOR[7:0];    end
      3'd2: begin init_addr = 3'd1; init_data = DIVISOR[15:8];   end
      3'd3: begin init_addr = 3'd3; init_data = LCR_VAL;         end
      3'd4: begin init_addr = 3'd2; init_data = FCR_VAL;         end
      3'd5: begin init_addr = 3'd1; init_data = 8'h00;           end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      init_idx   <= 3'd0;
      i_tx_en    <= 1'b0;
      i_rx_en    <= 1'b0;
      waddr      <= 3'd0;
      raddr      <= 3'd0;
      wdata      <= 8'h00;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      init_done  <= 1'b0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      i_tx_en    <= 1'b0;
      i_rx_en    <= 1'b0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rx_valid   <= 1'b0;
      case (state)
        INIT: begin
          if (init_idx == 3'd6) begin
            init_done <= 1'b1;
            state     <= POLL_ISSUE;
          end else begin
            i_tx_en  <= 1'b1;
            waddr    <= init_addr;
            wdata    <= init_data;
            init_idx <= init_idx + 3'd1;
          end
        end
        POLL_ISSUE: begin
          i_rx_en <= 1'b1;
          raddr   <= 3'd5;
          state   <= POLL_WAIT;
        end
        POLL_WAIT: state <= POLL_SAMPLE;
        // Pending RX data always wins so the receive FIFO cannot overrun
        POLL_SAMPLE: begin
          if (rdata[0]) begin
            state <= RX_ISSUE;
          end else if (rdata[5] && (req0_valid || req1_valid)) begin
            grant <= (req0_valid && req1_valid) ? ~last_grant : req1_valid;
            state <= TX_WRITE;
          end else begin
            state <= POLL_ISSUE;
          end
        end
        RX_ISSUE: begin
          i_rx_en <= 1'b1;
          raddr   <= 3'd0;
          state   <= RX_WAIT;
        end
        RX_WAIT: state <= RX_SAMPLE;
        RX_SAMPLE: begin
          rx_data  <= rdata;
          rx_valid <= 1'b1;
          state    <= POLL_ISSUE;
        end
        TX_WRITE: begin
          i_tx_en    <= 1'b1;
          waddr      <= 3'd0;
          wdata      <= grant ? req1_data : req0_data;
          req0_ready <= ~grant;
          req1_ready <= grant;
          last_grant <= grant;
          state      <= POLL_ISSUE;
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef UART_BUS_SCHED_ERR_EN
  logic [2:0] err_q;

  // LSR[3:1] is {FE,PE,OE}; a fresh error survives a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 3'b000;
    else if (state == POLL_SAMPLE)
      err_q <= (err_clr ? 3'b000 : err_q) | rdata[3:1];
    else if (err_clr)
      err_q <= 3'b000;
  end

  assign err_flags = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_flags = 3'b000;
`endif

endmodule

// File: tb/tb_uart_bus_sched.sv
// Directed bench for uart_bus_sched: LSR/RBR model, requester model and an event log of UART traffic.
module tb_uart_bus_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       init_done;
  logic [2:0] err_flags;
  logic       err_clr;
  logic       i_tx_en, i_rx_en;
  logic [2:0] waddr, raddr;
  logic [7:0] wdata, rdata;

  logic [7:0] lsr_val, rbr_val;
  logic       drop0, drop1;
  int         cyc, overlap_cnt;
  int         tests = 0, fails = 0;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] cyc;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  localparam logic [2:0] K_W = 3'd1, K_R = 3'd2, K_RDY0 = 3'd3, K_RDY1 = 3'd4, K_RX = 3'd5;

  ev_t log_q[$];
  ev_t exp_q[$];

`ifdef UART_BUS_SCHED_ERR_EN
  localparam logic [2:0] EXP_ERR  = 3'b101;
  localparam logic [2:0] EXP_PRIO = 3'b001;
`else
  localparam logic [2:0] EXP_ERR  = 3'b000;
  localparam logic [2:0] EXP_PRIO = 3'b000;
`endif

  always #5 clk = ~clk;

  // The held raddr selects which UART register is presented on rdata
  assign rdata = (raddr == 3'd5) ? lsr_val : rbr_val;

  uart_bus_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .init_done(init_done),
    .err_flags(err_flags), .err_clr(err_clr),
    .i_tx_en(i_tx_en), .waddr(waddr), .wdata(wdata),
    .i_rx_en(i_rx_en), .raddr(raddr), .rdata(rdata)
  );

  function automatic ev_t mk(logic [2:0] k, int c, logic [7:0] a, logic [7:0] d);
    logic [7:0] c8;
    c8 = c[7:0];
    return {k, c8, a, d};
  endfunction

  task automatic tick();
    logic [7:0] c8;
    @(negedge clk);
    cyc++;
    c8 = cyc[7:0];
    if (i_tx_en)    log_q.push_back({K_W, c8, {5'd0, waddr}, wdata});
    if (i_rx_en)    log_q.push_back({K_R, c8, {5'd0, raddr}, 8'h00});
    if (req0_ready) log_q.push_back({K_RDY0, c8, 8'h00, 8'h00});
    if (req1_ready) log_q.push_back({K_RDY1, c8, 8'h00, 8'h00});
    if (rx_valid)   log_q.push_back({K_RX, c8, 8'h00, rx_data});
    if ((i_tx_en && i_rx_en) || (req0_ready && req1_ready)) overlap_cnt++;
    if (req0_ready && drop0) req0_valid = 1'b0;
    if (req1_ready && drop1) req1_valid = 1'b0;
    if (i_rx_en && raddr == 3'd0) lsr_val[0] = 1'b0;
  endtask

  task automatic reset_and_init();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    repeat (7) tick();
    log_q.delete();
    exp_q.delete();
    overlap_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if ({i_tx_en, i_rx_en, req0_ready, req1_ready, rx_valid, init_done} !== 6'b0) begin
      fails++;
      $display("[TB] FAIL reset_strobes: got %b expected 000000",
               {i_tx_en, i_rx_en, req0_ready, req1_ready, rx_valid, init_done});
    end
    tests++;
    if ({waddr, raddr, wdata, rx_data} !== 22'd0) begin
      fails++;
      $display("[TB] FAIL reset_buses: got waddr=%0d raddr=%0d wdata=%h rx_data=%h expected zeros",
               waddr, raddr, wdata, rx_data);
    end
    tests++;
    if (err_flags !== 3'b000) begin
      fails++;
      $display("[TB] FAIL reset_err_flags: got %b expected 000", err_flags);
    end
  endtask

  task automatic test_init();
    logic [2:0] ea[6];
    logic [7:0] ed[6];
    ea = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2, 3'd1};
    ed = '{8'h83, 8'h0F, 8'h00, 8'h03, 8'h07, 8'h00};
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if ({i_tx_en, i_rx_en, init_done, waddr, wdata} !== {3'b100, ea[i], ed[i]}) begin
        fails++;
        $display("[TB] FAIL init_write%0d: got tx=%b rx=%b done=%b addr=%0d data=%h expected tx=1 rx=0 done=0 addr=%0d data=%h",
                 i + 1, i_tx_en, i_rx_en, init_done, waddr, wdata, ea[i], ed[i]);
      end
    end
    tick();
    tests++;
    if ({init_done, i_tx_en, i_rx_en} !== 3'b100) begin
      fails++;
      $display("[TB] FAIL init_done_c7: got done=%b tx=%b rx=%b expected 1 0 0", init_done, i_tx_en, i_rx_en);
    end
    tick();
    tests++;
    if ({i_rx_en, raddr, init_done} !== {1'b1, 3'd5, 1'b1}) begin
      fails++;
      $display("[TB] FAIL first_poll: got rx=%b raddr=%0d done=%b expected 1 5 1", i_rx_en, raddr, init_done);
    end
  endtask

  task automatic test_tx_single();
    lsr_val = 8'h20; rbr_val = 8'h00; err_clr = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h41; req1_valid = 1'b0; req1_data = 8'h00;
    drop0 = 1'b1; drop1 = 1'b1;
    reset_and_init();
    repeat (8) tick();
    exp_q = '{mk(K_R, 8, 8'd5, 8'h00), mk(K_W, 11, 8'd0, 8'h41), mk(K_RDY0, 11, 8'h00, 8'h00),
              mk(K_R, 12, 8'd5, 8'h00), mk(K_R, 15, 8'd5, 8'h00)};
    tests++;
    if (log_q.size() != exp_q.size()) begin
      fails++;
      $display("[TB] FAIL tx_single_count: got %0d events expected %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL tx_single_ev%0d: got %h expected %h", i,
                 (i < log_q.size()) ? log_q[i] : ev_t'(0), exp_q[i]);
      end
    end
    tests++;
    if (overlap_cnt != 0) begin
      fails++;
      $display("[TB] FAIL tx_single_overlap: got %0d expected 0", overlap_cnt);
    end
  endtask

  task automatic test_rx_priority();
    lsr_val = 8'h21; rbr_val = 8'h5A; err_clr = 1'b0;
    req0_valid = 1'b0; req0_data = 8'h00; req1_valid = 1'b1; req1_data = 8'h77;
    drop0 = 1'b1; drop1 = 1'b1;
    reset_and_init();
    repeat (14) tick();
    exp_q = '{mk(K_R, 8, 8'd5, 8'h00), mk(K_R, 11, 8'd0, 8'h00), mk(K_RX, 13, 8'h00, 8'h5A),
              mk(K_R, 14, 8'd5, 8'h00), mk(K_W, 17, 8'd0, 8'h77), mk(K_RDY1, 17, 8'h00, 8'h00),
              mk(K_R, 18, 8'd5, 8'h00), mk(K_R, 21, 8'd5, 8'h00)};
    tests++;
    if (log_q.size() != exp_q.size()) begin
      fails++;
      $display("[TB] FAIL rx_prio_count: got %0d events expected %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL rx_prio_ev%0d: got %h expected %h", i,
                 (i < log_q.size()) ? log_q[i] : ev_t'(0), exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    lsr_val = 8'h20; rbr_val = 8'h00; err_clr = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h11; req1_valid = 1'b1; req1_data = 8'h22;
    drop0 = 1'b0; drop1 = 1'b0;
    reset_and_init();
    repeat (16) tick();
    exp_q = '{mk(K_R, 8, 8'd5, 8'h00),
              mk(K_W, 11, 8'd0, 8'h11), mk(K_RDY0, 11, 8'h00, 8'h00), mk(K_R, 12, 8'd5, 8'h00),
              mk(K_W, 15, 8'd0, 8'h22), mk(K_RDY1, 15, 8'h00, 8'h00), mk(K_R, 16, 8'd5, 8'h00),
              mk(K_W, 19, 8'd0, 8'h11), mk(K_RDY0, 19, 8'h00, 8'h00), mk(K_R, 20, 8'd5, 8'h00),
              mk(K_W, 23, 8'd0, 8'h22), mk(K_RDY1, 23, 8'h00, 8'h00)};
    tests++;
    if (log_q.size() != exp_q.size()) begin
      fails++;
      $display("[TB] FAIL rr_count: got %0d events expected %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL rr_ev%0d: got %h expected %h", i,
                 (i < log_q.size()) ? log_q[i] : ev_t'(0), exp_q[i]);
      end
    end
    tests++;
    if (overlap_cnt != 0) begin
      fails++;
      $display("[TB] FAIL rr_overlap: got %0d expected 0", overlap_cnt);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid_rx();
    lsr_val = 8'h21; rbr_val = 8'h5A; err_clr = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h41; req1_valid = 1'b0; req1_data = 8'h00;
    drop0 = 1'b1; drop1 = 1'b1;
    reset_and_init();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
    repeat (7) tick();
    exp_q = '{mk(K_R, 8, 8'd5, 8'h00), mk(K_R, 11, 8'd0, 8'h00),
              mk(K_W, 1, 8'd3, 8'h83), mk(K_W, 2, 8'd0, 8'h0F), mk(K_W, 3, 8'd1, 8'h00),
              mk(K_W, 4, 8'd3, 8'h03), mk(K_W, 5, 8'd2, 8'h07), mk(K_W, 6, 8'd1, 8'h00)};
    tests++;
    if (log_q.size() != exp_q.size()) begin
      fails++;
      $display("[TB] FAIL rst_mid_count: got %0d events expected %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL rst_mid_ev%0d: got %h expected %h", i,
                 (i < log_q.size()) ? log_q[i] : ev_t'(0), exp_q[i]);
      end
    end
    tests++;
    if ({init_done, req0_valid} !== 2'b11) begin
      fails++;
      $display("[TB] FAIL rst_mid_done: got done=%b req0_valid=%b expected 1 1", init_done, req0_valid);
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_err_flags();
    lsr_val = 8'h0A; rbr_val = 8'h00; err_clr = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drop0 = 1'b1; drop1 = 1'b1;
    reset_and_init();
    repeat (2) tick();
    tests++;
    if (err_flags !== 3'b000) begin
      fails++;
      $display("[TB] FAIL err_before_sample: got %b expected 000", err_flags);
    end
    tick();
    lsr_val = 8'h00;
    tests++;
    if (err_flags !== EXP_ERR) begin
      fails++;
      $display("[TB] FAIL err_set: got %b expected %b", err_flags, EXP_ERR);
    end
    repeat (5) tick();
    tests++;
    if (err_flags !== EXP_ERR) begin
      fails++;
      $display("[TB] FAIL err_sticky: got %b expected %b", err_flags, EXP_ERR);
    end
    err_clr = 1'b1;
    tick();
    tests++;
    if (err_flags !== 3'b000) begin
      fails++;
      $display("[TB] FAIL err_clear: got %b expected 000", err_flags);
    end
    lsr_val = 8'h02;
    repeat (3) tick();
    tests++;
    if (err_flags !== EXP_PRIO) begin
      fails++;
      $display("[TB] FAIL err_set_over_clear: got %b expected %b", err_flags, EXP_PRIO);
    end
    err_clr = 1'b0;
    lsr_val = 8'h00;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_data = 8'h00;
    err_clr = 1'b0;
    lsr_val = 8'h00; rbr_val = 8'h00;
    drop0 = 1'b1; drop1 = 1'b1;
    cyc = 0; overlap_cnt = 0;
    test_reset();
    test_init();
    test_tx_single();
    test_rx_priority();
    test_back_to_back();
    test_reset_mid_rx();
    test_err_flags();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
